// File: rtl/aexm_dmem_ctrl.sv
// Data-memory controller: one posted-store buffer plus a blocking load path
// onto a single-request ack bus, with a per-request timeout.
module aexm_dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        dmem_stb,
    input  logic        dmem_we,
    input  logic [29:0] dmem_adr,
    input  logic [3:0]  dmem_sel,
    input  logic [31:0] dmem_dato,
    output logic [31:0] dmem_dati,
    output logic        dmem_stall,
    output logic        dmem_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_adr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_dato,
    input  logic        mem_ack,
    input  logic [31:0] mem_dati
);

    localparam int unsigned AW = 30;
    localparam int unsigned SW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RDONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_adr_q;
    logic [SW-1:0] mem_sel_q;
    logic [DW-1:0] mem_dato_q;
    logic [DW-1:0] dmem_dati_q;
    logic          dmem_err_q;

    logic acc_c;
    logic issue_c;
    logic timeout_c;

    assign acc_c     = dmem_stb & (|dmem_sel);
    // A new request may start from IDLE, or seamlessly as the store buffer drains.
    assign issue_c   = acc_c & ((state_q == IDLE) | ((state_q == WR) & mem_ack));
    // An ack on the final cycle wins over the timeout.
    assign timeout_c = (cnt_q == TO_LAST) & ~mem_ack;

    // Stall is the only combinational output; forced low while in reset.
    always_comb begin
        dmem_stall = 1'b0;
        if (!grst) begin
            case (state_q)
                IDLE:    dmem_stall = acc_c & ~dmem_we;
                WR:      dmem_stall = acc_c & (~mem_ack | ~dmem_we);
                RD:      dmem_stall = 1'b1;
                default: dmem_stall = 1'b0;
            endcase
        end
    end

    // Controller FSM; the mem_* registers double as the posted-store buffer.
    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_sel_q   <= '0;
            mem_dato_q  <= '0;
            dmem_dati_q <= '0;
            dmem_err_q  <= 1'b0;
        end else begin
            dmem_err_q <= 1'b0;
            if (issue_c) begin
                state_q    <= dmem_we ? WR : RD;
                cnt_q      <= '0;
                mem_req_q  <= 1'b1;
                mem_we_q   <= dmem_we;
                mem_adr_q  <= dmem_adr;
                mem_sel_q  <= dmem_sel;
                mem_dato_q <= dmem_dato;
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    WR: begin
                        if (mem_ack) begin
                            mem_req_q <= 1'b0;
                            state_q   <= IDLE;
                        end else if (timeout_c) begin
                            mem_req_q  <= 1'b0;
                            dmem_err_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    RD: begin
                        if (mem_ack) begin
                            dmem_dati_q <= mem_dati;
                            mem_req_q   <= 1'b0;
                            state_q     <= RDONE;
                        end else if (timeout_c) begin
                            dmem_dati_q <= 32'hFFFF_FFFF;
                            mem_req_q   <= 1'b0;
                            dmem_err_q  <= 1'b1;
                            state_q     <= RDONE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    RDONE:   state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_sel   = mem_sel_q;
    assign mem_dato  = mem_dato_q;
    assign dmem_dati = dmem_dati_q;
    assign dmem_err  = dmem_err_q;

endmodule

// File: tb/tb_aexm_dmem_ctrl.sv
// Scoreboard bench for aexm_dmem_ctrl: directed accesses push expected bus
// handshakes and load results; a negedge monitor pops and compares them.
module tb_aexm_dmem_ctrl;

    localparam int unsigned TO = 4;

    typedef struct packed {
        logic        we;
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [31:0] dato;
    } bus_t;

    logic        gclk = 1'b0;
    logic        grst;
    logic        dmem_stb;
    logic        dmem_we;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_sel;
    logic [31:0] dmem_dato;
    logic [31:0] dmem_dati;
    logic        dmem_stall;
    logic        dmem_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_adr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_dato;
    logic        mem_ack;
    logic [31:0] mem_dati;

    int n_cmp = 0;
    int n_mis = 0;

    bus_t        bus_q[$];
    logic [31:0] ld_q[$];
    bus_t        mon_b;
    logic [31:0] mon_d;

    aexm_dmem_ctrl #(.TIMEOUT(TO)) dut (
        .gclk      (gclk),
        .grst      (grst),
        .dmem_stb  (dmem_stb),
        .dmem_we   (dmem_we),
        .dmem_adr  (dmem_adr),
        .dmem_sel  (dmem_sel),
        .dmem_dato (dmem_dato),
        .dmem_dati (dmem_dati),
        .dmem_stall(dmem_stall),
        .dmem_err  (dmem_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_sel   (mem_sel),
        .mem_dato  (mem_dato),
        .mem_ack   (mem_ack),
        .mem_dati  (mem_dati)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs change 1 time unit after the rising edge, checks follow at +3.
    task automatic cyc(input logic rst, input logic stb, input logic we, input logic [29:0] adr,
                       input logic [3:0] sel, input logic [31:0] dato, input logic ack,
                       input logic [31:0] rdat);
        @(posedge gclk);
        #1;
        grst      = rst;
        dmem_stb  = stb;
        dmem_we   = we;
        dmem_adr  = adr;
        dmem_sel  = sel;
        dmem_dato = dato;
        mem_ack   = ack;
        mem_dati  = rdat;
        #2;
    endtask

    task automatic idle(input logic ack);
        cyc(1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, ack, 32'h0);
    endtask

    task automatic push_bus(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                            input logic [31:0] dato);
        bus_t b;
        b.we   = we;
        b.adr  = adr;
        b.sel  = sel;
        b.dato = dato;
        bus_q.push_back(b);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_req"},  32'(mem_req),   32'h0);
        chk({tag, "_mem_we"},   32'(mem_we),    32'h0);
        chk({tag, "_mem_adr"},  32'(mem_adr),   32'h0);
        chk({tag, "_mem_sel"},  32'(mem_sel),   32'h0);
        chk({tag, "_mem_dato"}, mem_dato,       32'h0);
        chk({tag, "_dati"},     dmem_dati,      32'h0);
        chk({tag, "_err"},      32'(dmem_err),  32'h0);
        chk({tag, "_stall"},    32'(dmem_stall), 32'h0);
    endtask

    // Monitor: bus handshakes and completed loads are checked against the queues.
    always @(negedge gclk) begin
        if (grst === 1'b0 && mem_req === 1'b1 && mem_ack === 1'b1) begin
            if (bus_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL bus_unexpected: got ack for adr %h, expected none", mem_adr);
            end else begin
                mon_b = bus_q.pop_front();
                chk("bus_we",  32'(mem_we),  32'(mon_b.we));
                chk("bus_adr", 32'(mem_adr), 32'(mon_b.adr));
                chk("bus_sel", 32'(mem_sel), 32'(mon_b.sel));
                if (mon_b.we) chk("bus_dato", mem_dato, mon_b.dato);
            end
        end
        if (grst === 1'b0 && dmem_stb === 1'b1 && dmem_we === 1'b0 && dmem_sel != 4'h0
            && dmem_stall === 1'b0) begin
            if (ld_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL load_unexpected: got load completion %h, expected none", dmem_dati);
            end else begin
                mon_d = ld_q.pop_front();
                chk("load_data", dmem_dati, mon_d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        grst = 1'b1; dmem_stb = 1'b0; dmem_we = 1'b0; dmem_adr = '0; dmem_sel = '0;
        dmem_dato = '0; mem_ack = 1'b0; mem_dati = '0;

        // Reset and the first cycle after it
        cyc(1'b1, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        chk("rst_stall", 32'(dmem_stall), 32'h0);
        chk("rst_req",   32'(mem_req),    32'h0);
        idle(1'b0);
        chk_reset_vals("post_rst");

        // Single store, ack on the third request cycle
        push_bus(1'b1, 30'h100, 4'hF, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b1, 1'b1, 30'h100, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0);
        chk("st1_stall", 32'(dmem_stall), 32'h0);
        idle(1'b0);
        chk("st1_req1",  32'(mem_req),  32'h1);
        chk("st1_we",    32'(mem_we),   32'h1);
        chk("st1_adr",   32'(mem_adr),  32'h100);
        chk("st1_sel",   32'(mem_sel),  32'hF);
        chk("st1_dato",  mem_dato,      32'hDEAD_BEEF);
        idle(1'b0);
        chk("st1_req2",  32'(mem_req),  32'h1);
        idle(1'b1);
        chk("st1_req3",  32'(mem_req),  32'h1);
        idle(1'b0);
        chk("st1_req_off", 32'(mem_req), 32'h0);

        // Back-to-back stores: second waits one cycle, request stays high
        push_bus(1'b1, 30'h10, 4'hF, 32'h1111_1111);
        cyc(1'b0, 1'b1, 1'b1, 30'h10, 4'hF, 32'h1111_1111, 1'b0, 32'h0);
        chk("b2b_stall0", 32'(dmem_stall), 32'h0);
        push_bus(1'b1, 30'h14, 4'h3, 32'h2222_2222);
        cyc(1'b0, 1'b1, 1'b1, 30'h14, 4'h3, 32'h2222_2222, 1'b0, 32'h0);
        chk("b2b_stall1", 32'(dmem_stall), 32'h1);
        cyc(1'b0, 1'b1, 1'b1, 30'h14, 4'h3, 32'h2222_2222, 1'b1, 32'h0);
        chk("b2b_stall2", 32'(dmem_stall), 32'h0);
        chk("b2b_req_a",  32'(mem_req),    32'h1);
        idle(1'b1);
        chk("b2b_req_b",  32'(mem_req),    32'h1);
        chk("b2b_adr_b",  32'(mem_adr),    32'h14);
        idle(1'b0);
        chk("b2b_req_off", 32'(mem_req),   32'h0);

        // Store then load of the same address: load waits for the store ack
        push_bus(1'b1, 30'h20, 4'hF, 32'hAAAA_5555);
        cyc(1'b0, 1'b1, 1'b1, 30'h20, 4'hF, 32'hAAAA_5555, 1'b0, 32'h0);
        chk("sl_stall_st", 32'(dmem_stall), 32'h0);
        push_bus(1'b0, 30'h20, 4'hF, 32'h0);
        ld_q.push_back(32'h1234_5678);
        cyc(1'b0, 1'b1, 1'b0, 30'h20, 4'hF, 32'h0, 1'b0, 32'h0);
        chk("sl_stall_a", 32'(dmem_stall), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 30'h20, 4'hF, 32'h0, 1'b1, 32'h0);
        chk("sl_stall_b", 32'(dmem_stall), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 30'h20, 4'hF, 32'h0, 1'b1, 32'h1234_5678);
        chk("sl_rd_req",  32'(mem_req),    32'h1);
        chk("sl_rd_we",   32'(mem_we),     32'h0);
        chk("sl_stall_c", 32'(dmem_stall), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 30'h20, 4'hF, 32'h0, 1'b0, 32'h0);
        chk("sl_rdone_stall", 32'(dmem_stall), 32'h0);
        chk("sl_rdone_req",   32'(mem_req),    32'h0);
        idle(1'b0);
        chk("sl_dati_hold", dmem_dati, 32'h1234_5678);

        // Strobe with no lanes selected is ignored, as is a stray ack
        cyc(1'b0, 1'b1, 1'b0, 30'h28, 4'h0, 32'h0, 1'b1, 32'h0);
        chk("sel0_stall", 32'(dmem_stall), 32'h0);
        idle(1'b0);
        chk("sel0_req",   32'(mem_req),    32'h0);

        // Load with no ack: timeout after TO request cycles
        ld_q.push_back(32'hFFFF_FFFF);
        cyc(1'b0, 1'b1, 1'b0, 30'h30, 4'h1, 32'h0, 1'b0, 32'h0);
        chk("rto_stall0", 32'(dmem_stall), 32'h1);
        for (int i = 0; i < int'(TO); i++) begin
            cyc(1'b0, 1'b1, 1'b0, 30'h30, 4'h1, 32'h0, 1'b0, 32'h0);
            chk("rto_req", 32'(mem_req),  32'h1);
            chk("rto_err0", 32'(dmem_err), 32'h0);
        end
        cyc(1'b0, 1'b1, 1'b0, 30'h30, 4'h1, 32'h0, 1'b0, 32'h0);
        chk("rto_req_off", 32'(mem_req),    32'h0);
        chk("rto_err",     32'(dmem_err),   32'h1);
        chk("rto_dati",    dmem_dati,       32'hFFFF_FFFF);
        chk("rto_stall",   32'(dmem_stall), 32'h0);
        idle(1'b0);
        chk("rto_err_end", 32'(dmem_err),   32'h0);

        // Ack in the last allowed cycle is a normal completion
        push_bus(1'b0, 30'h34, 4'hF, 32'h0);
        ld_q.push_back(32'h5A5A_A5A5);
        cyc(1'b0, 1'b1, 1'b0, 30'h34, 4'hF, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < int'(TO) - 1; i++)
            cyc(1'b0, 1'b1, 1'b0, 30'h34, 4'hF, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 30'h34, 4'hF, 32'h0, 1'b1, 32'h5A5A_A5A5);
        chk("edge_req", 32'(mem_req), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 30'h34, 4'hF, 32'h0, 1'b0, 32'h0);
        chk("edge_err",   32'(dmem_err),   32'h0);
        chk("edge_stall", 32'(dmem_stall), 32'h0);
        idle(1'b0);

        // Store with no ack: timeout discards the buffer
        cyc(1'b0, 1'b1, 1'b1, 30'h50, 4'hF, 32'h5555_5555, 1'b0, 32'h0);
        for (int i = 0; i < int'(TO); i++) idle(1'b0);
        chk("wto_req3", 32'(mem_req), 32'h1);
        idle(1'b0);
        chk("wto_req_off", 32'(mem_req),  32'h0);
        chk("wto_err",     32'(dmem_err), 32'h1);
        idle(1'b0);
        chk("wto_err_end", 32'(dmem_err), 32'h0);
        push_bus(1'b1, 30'h60, 4'h2, 32'h6666_6666);
        cyc(1'b0, 1'b1, 1'b1, 30'h60, 4'h2, 32'h6666_6666, 1'b0, 32'h0);
        chk("wto_next_stall", 32'(dmem_stall), 32'h0);
        idle(1'b1);
        idle(1'b0);
        chk("wto_next_off", 32'(mem_req), 32'h0);

        // Reset during an outstanding load, followed by a late ack
        cyc(1'b0, 1'b1, 1'b0, 30'h40, 4'hF, 32'h0, 1'b0, 32'h0);
        chk("mrst_stall", 32'(dmem_stall), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        chk("mrst_req_rd",  32'(mem_req),    32'h1);
        chk("mrst_stall_r", 32'(dmem_stall), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 1'b1, 32'hBAD0_BAD0);
        chk_reset_vals("mrst");
        idle(1'b0);
        chk("mrst_late_req",  32'(mem_req),  32'h0);
        chk("mrst_late_dati", dmem_dati,     32'h0);
        chk("mrst_late_err",  32'(dmem_err), 32'h0);
        push_bus(1'b0, 30'h44, 4'hF, 32'h0);
        ld_q.push_back(32'hCAFE_F00D);
        cyc(1'b0, 1'b1, 1'b0, 30'h44, 4'hF, 32'h0, 1'b0, 32'h0);
        chk("mrst_ld_stall", 32'(dmem_stall), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 30'h44, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D);
        chk("mrst_ld_req", 32'(mem_req), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 30'h44, 4'hF, 32'h0, 1'b0, 32'h0);
        chk("mrst_ld_done", 32'(dmem_stall), 32'h0);
        idle(1'b0);
        idle(1'b0);

        chk("bus_q_empty",  32'(bus_q.size()), 32'h0);
        chk("load_q_empty", 32'(ld_q.size()),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
